// File: rtl/sr_sched_pkg.sv
// ---------------------------------------------------------------------------
// sr_sched_pkg
// Shared definitions for the SR-bank scheduler: operation encodings,
// default sizing constants and the round-robin pointer rotation helper.
// Ports: none (package).
// ---------------------------------------------------------------------------
package sr_sched_pkg;

    // Operation encoding carried on req_set
    localparam logic OP_RESET = 1'b0;
    localparam logic OP_SET   = 1'b1;

    // Default sizing of the scheduler
    localparam int DEF_NREQ  = 4;
    localparam int DEF_NFLAG = 8;
    localparam int DEF_IDXW  = 3;

    // Pointer position just after the winner, wrapping modulo n
    function automatic int next_ptr(input int winner, input int n);
        return (winner + 1 >= n) ? 0 : winner + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority arbiter. The search starts at ptr
// and wraps modulo N; the first active request wins.
// Ports:
//   req    in  N   request vector
//   ptr    in  PW  highest-priority position for this cycle
//   gnt    out N   one-hot grant (all zero when req is all zero)
//   winner out PW  encoded index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] winner
);

    // Walk the request vector starting at ptr; only the first hit is kept
    always_comb begin
        logic found;
        int   pos;
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) pos = pos - N;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                winner   = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/sr_bank_sched.sv
// ---------------------------------------------------------------------------
// sr_bank_sched
// Shares one bank of NFLAG SR flip-flops between NREQ requesters. One request
// is granted per cycle (round robin), turned into a single-cycle s or r pulse
// on the targeted flop, and mirrored into a shadow copy q one cycle later.
// Optional feature macro: SRSCHED_ERR_EN adds a sticky err output that flags
// transfers whose index is outside the bank.
// Ports:
//   clk      in  1          clock, rising edge
//   reset    in  1          asynchronous, active low
//   req      in  NREQ       per-requester request valid
//   req_set  in  NREQ       1 = set flag, 0 = reset flag
//   req_idx  in  NREQ*IDXW  target index, requester k at [k*IDXW +: IDXW]
//   gnt      out NREQ       one-hot grant (combinational)
//   s        out NFLAG      registered set pulses
//   r        out NFLAG      registered reset pulses
//   q        out NFLAG      shadow of the bank state
//   busy     out 1          any request pending (combinational)
//   err      out 1          sticky out-of-range flag (SRSCHED_ERR_EN only)
// ---------------------------------------------------------------------------
module sr_bank_sched
    import sr_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int NFLAG = DEF_NFLAG,
    parameter int IDXW  = DEF_IDXW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_set,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      gnt,
    output logic [NFLAG-1:0]     s,
    output logic [NFLAG-1:0]     r,
    output logic [NFLAG-1:0]     q,
    output logic                 busy
`ifdef SRSCHED_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    winner;
    logic             transfer;
    logic [IDXW-1:0]  sel_idx;
    logic             sel_set;
    logic             in_range;
    logic [NFLAG-1:0] s_nxt;
    logic [NFLAG-1:0] r_nxt;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .gnt    (gnt),
        .winner (winner)
    );

    assign busy     = |req;
    assign transfer = |gnt;
    assign sel_idx  = req_idx[int'(winner)*IDXW +: IDXW];
    assign sel_set  = req_set[winner];
    assign in_range = int'(sel_idx) < NFLAG;

    // Decode the granted request into a one-hot set or reset pulse; the two
    // vectors are built from complementary conditions so s & r is always 0
    always_comb begin
        s_nxt = '0;
        r_nxt = '0;
        if (transfer && in_range) begin
            for (int f = 0; f < NFLAG; f++) begin
                if (int'(sel_idx) == f) begin
                    s_nxt[f] = (sel_set == OP_SET);
                    r_nxt[f] = (sel_set == OP_RESET);
                end
            end
        end
    end

    // Pulses last one cycle; q follows the pulse on the next edge, matching
    // the lag of the real flop bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
            s   <= '0;
            r   <= '0;
            q   <= '0;
        end else begin
            s <= s_nxt;
            r <= r_nxt;
            q <= (q | s) & ~r;
            if (transfer) ptr <= PW'(next_ptr(int'(winner), NREQ));
        end
    end

`ifdef SRSCHED_ERR_EN
    // Sticky flag for consumed requests that target a flop outside the bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (transfer && !in_range) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sr_bank_sched.sv
// ---------------------------------------------------------------------------
// tb_sr_bank_sched
// Self-checking bench for sr_bank_sched (NREQ=4, NFLAG=6, IDXW=3). A
// transaction-level model tracks the pointer, the pending pulse and the
// shadow flags; directed scenarios are followed by randomized traffic.
// Honours SRSCHED_ERR_EN when defined.
// ---------------------------------------------------------------------------
module tb_sr_bank_sched;

    localparam int NREQ  = 4;
    localparam int NFLAG = 6;
    localparam int IDXW  = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      req_set = '0;
    logic [NREQ*IDXW-1:0] req_idx = '0;
    logic [NREQ-1:0]      gnt;
    logic [NFLAG-1:0]     s;
    logic [NFLAG-1:0]     r;
    logic [NFLAG-1:0]     q;
    logic                 busy;
`ifdef SRSCHED_ERR_EN
    logic                 err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int               m_ptr;
    logic [NFLAG-1:0] m_q;
    bit               p_valid;
    int               p_idx;
    bit               p_op;
    bit               m_err;
    int               m_win;
    logic [NREQ-1:0]  g_obs;

    // Random-traffic bookkeeping: a requester holds its request until granted
    bit               r_pend [NREQ];
    bit               r_set  [NREQ];
    int               r_idx  [NREQ];

    sr_bank_sched #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_set (req_set),
        .req_idx (req_idx),
        .gnt     (gnt),
        .s       (s),
        .r       (r),
        .q       (q),
        .busy    (busy)
`ifdef SRSCHED_ERR_EN
        ,
        .err     (err)
`endif
    );

    always #5 clk = ~clk;

    // Guards against a hung run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Asserts reset, checks the immediate clear, releases it at a falling edge
    task automatic applyReset();
        req     = '0;
        req_set = '0;
        req_idx = '0;
        reset   = 1'b0;
        #1;
        m_ptr   = 0;
        m_q     = '0;
        p_valid = 0;
        m_err   = 0;
        checkOutput("rst_s", 32'(s), 32'd0);
        checkOutput("rst_r", 32'(r), 32'd0);
        checkOutput("rst_q", 32'(q), 32'd0);
`ifdef SRSCHED_ERR_EN
        checkOutput("rst_err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One cycle: drive inputs, check the combinational grant, clock, update
    // the model and check the registered outputs
    task automatic applyStimulus(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] rs,
                                 input logic [NREQ*IDXW-1:0] ri);
        int               idx;
        int               k;
        logic [NFLAG-1:0] es;
        logic [NFLAG-1:0] er;
        @(negedge clk);
        req     = rq;
        req_set = rs;
        req_idx = ri;
        #1;
        m_win = -1;
        for (int i = 0; i < NREQ; i++) begin
            k = (m_ptr + i) % NREQ;
            if (m_win < 0 && rq[k]) m_win = k;
        end
        g_obs = gnt;
        checkOutput("gnt", 32'(gnt), (m_win >= 0) ? (32'd1 << m_win) : 32'd0);
        checkOutput("busy", 32'(busy), (rq != '0) ? 32'd1 : 32'd0);
        @(posedge clk);
        if (p_valid) m_q[p_idx] = p_op;
        p_valid = 0;
        if (m_win >= 0) begin
            idx = int'(ri[m_win*IDXW +: IDXW]);
            if (idx < NFLAG) begin
                p_valid = 1;
                p_idx   = idx;
                p_op    = rs[m_win];
            end else begin
                m_err = 1;
            end
            m_ptr = (m_win + 1) % NREQ;
        end
        #1;
        es = '0;
        er = '0;
        if (p_valid) begin
            if (p_op) es[p_idx] = 1'b1;
            else      er[p_idx] = 1'b1;
        end
        checkOutput("s", 32'(s), 32'(es));
        checkOutput("r", 32'(r), 32'(er));
        checkOutput("q", 32'(q), 32'(m_q));
        checkOutput("s_and_r", 32'(s & r), 32'd0);
`ifdef SRSCHED_ERR_EN
        checkOutput("err", 32'(err), 32'(m_err));
`endif
    endtask

    initial begin
        logic [NREQ-1:0]      vr;
        logic [NREQ-1:0]      vs;
        logic [NREQ*IDXW-1:0] vi;

        applyReset();

        // Single set of flag 5 from requester 0
        applyStimulus(4'b0001, 4'b0001, 12'h005);
        checkOutput("d1_gnt", 32'(g_obs), 32'h1);
        checkOutput("d1_s", 32'(s), 32'h20);
        checkOutput("d1_r", 32'(r), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 12'h000);
        checkOutput("d1_q", 32'(q), 32'h20);

        // Full contention from ptr=0: grants rotate 0,1,2,3,0
        applyReset();
        applyStimulus(4'b1111, 4'b1111, 12'h688);
        checkOutput("rr_g0", 32'(g_obs), 32'h1);
        applyStimulus(4'b1111, 4'b1111, 12'h688);
        checkOutput("rr_g1", 32'(g_obs), 32'h2);
        applyStimulus(4'b1111, 4'b1111, 12'h688);
        checkOutput("rr_g2", 32'(g_obs), 32'h4);
        applyStimulus(4'b1111, 4'b1111, 12'h688);
        checkOutput("rr_g3", 32'(g_obs), 32'h8);
        applyStimulus(4'b1111, 4'b1111, 12'h688);
        checkOutput("rr_wrap", 32'(g_obs), 32'h1);

        // Same index: req0 sets flag 2, req1 resets flag 2
        applyReset();
        applyStimulus(4'b0011, 4'b0001, 12'h012);
        checkOutput("same_g0", 32'(g_obs), 32'h1);
        checkOutput("same_s", 32'(s), 32'h04);
        applyStimulus(4'b0010, 4'b0000, 12'h012);
        checkOutput("same_g1", 32'(g_obs), 32'h2);
        checkOutput("same_r", 32'(r), 32'h04);
        checkOutput("same_q_mid", 32'(q), 32'h04);
        applyStimulus(4'b0000, 4'b0000, 12'h000);
        checkOutput("same_q_end", 32'(q), 32'h00);

        // Out-of-range index 7 on requester 2, with flag 4 already set
        applyStimulus(4'b0001, 4'b0001, 12'h004);
        applyStimulus(4'b0000, 4'b0000, 12'h000);
        applyStimulus(4'b0100, 4'b0100, 12'h1C0);
        checkOutput("oor_gnt", 32'(g_obs), 32'h4);
        checkOutput("oor_s", 32'(s), 32'h0);
        checkOutput("oor_r", 32'(r), 32'h0);
        checkOutput("oor_q", 32'(q), 32'h10);
`ifdef SRSCHED_ERR_EN
        checkOutput("oor_err", 32'(err), 32'h1);
`endif

        // Idle bus for five cycles
        for (int c = 0; c < 5; c++) applyStimulus(4'b0000, 4'b0000, 12'h000);
        checkOutput("idle_q", 32'(q), 32'h10);
`ifdef SRSCHED_ERR_EN
        checkOutput("idle_err", 32'(err), 32'h1);
`endif

        // Reset while an s pulse is on the bank
        applyStimulus(4'b0001, 4'b0001, 12'h001);
        applyStimulus(4'b0010, 4'b0010, 12'h018);
        checkOutput("mid_s_hi", 32'(s), 32'h08);
        #1;
        applyReset();
        applyStimulus(4'b1111, 4'b0000, 12'h000);
        checkOutput("mid_ptr0", 32'(g_obs), 32'h1);

        // Randomized traffic honouring the hold-until-granted handshake
        for (int k = 0; k < NREQ; k++) r_pend[k] = 0;
        for (int c = 0; c < 400; c++) begin
            vr = '0;
            vs = '0;
            vi = '0;
            for (int k = 0; k < NREQ; k++) begin
                if (!r_pend[k] && ($urandom_range(0, 1) == 1)) begin
                    r_pend[k] = 1;
                    r_set[k]  = ($urandom_range(0, 1) == 1);
                    r_idx[k]  = int'($urandom_range(0, 7));
                end
                vr[k] = r_pend[k];
                vs[k] = r_set[k];
                vi[k*IDXW +: IDXW] = IDXW'(r_idx[k]);
            end
            applyStimulus(vr, vs, vi);
            if (m_win >= 0) r_pend[m_win] = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_bank_sched.md
# sr_bank_sched

Round-robin scheduler that shares one bank of NFLAG SR flip-flops between NREQ requesters. Each requester asks to set or reset one flag; the block grants one request per cycle and drives a single-cycle s/r pulse to the targeted flop. It guarantees that s and r are never both high on any bit. It sits between control agents and the srff bank and keeps a shadow copy of the bank state.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- NFLAG, 8, number of SR flops in the bank
- IDXW, 3, flag index width; must satisfy 2^IDXW >= NFLAG

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted low clears all state
- req  in  NREQ  per-requester request valid
- req_set  in  NREQ  op per requester: 1 = set flag, 0 = reset flag
- req_idx  in  NREQ*IDXW  flattened target index, requester k at bits [k*IDXW +: IDXW]
- gnt  out  NREQ  one-hot grant, combinational from req and priority pointer
- s  out  NFLAG  registered set pulses to SR bank
- r  out  NFLAG  registered reset pulses to SR bank
- q  out  NFLAG  shadow of bank state
- busy  out  1  high when any req bit is high, combinational

## Operation
- Handshake: a requester holds req, req_set and req_idx stable until it sees gnt high. A transfer occurs on the rising edge where req[k] & gnt[k]. The requester may drop req, or present a new request, in the following cycle.
- Arbitration: rotating pointer ptr (log2 NREQ bits). The winner is the first k with req[k]=1, searching ptr, ptr+1, … with wrap modulo NREQ. After a transfer, ptr <= winner+1 mod NREQ. With no transfer, ptr holds. At most one gnt bit is high; gnt is all zero when req is all zero.
- Pulse generation: on a transfer with idx < NFLAG, on the next edge s[idx] <= req_set and r[idx] <= ~req_set. All other s/r bits are 0. Without a transfer, s = r = 0. The pulse lasts exactly one cycle.
- Shadow: on the edge after a pulse, q[idx] takes the pulsed value (set→1, reset→0), tracking the bank with the same one-cycle lag as the flop.
- Same index from two requesters: the operations are serialized in grant order; the last grant wins in q.
- Out-of-range idx (≥ NFLAG): the request is granted (consumed), no s/r pulse is issued, and q is unchanged.
- Invariant: (s & r) == 0 every cycle.

## Timing
- Reset values: s = 0, r = 0, q = 0, ptr = 0, err = 0. gnt and busy follow req combinationally (gnt is valid as soon as reset is released).
- Reset asserted mid-operation: a pending s/r pulse is discarded immediately (asynchronous), and q clears.
- Latency: handshake edge T → s/r pulse during cycle T+1 → q updated after edge T+2.
- Throughput: one grant per cycle. A requester that keeps req high continuously is granted at most once every NREQ cycles when all requesters contend.

## Configuration
- SRSCHED_ERR_EN defined:
  - adds port err (out, 1), a sticky error flag;
  - err is set on the edge of a transfer with idx ≥ NFLAG;
  - err is cleared only by reset.
- SRSCHED_ERR_EN undefined: no err port; out-of-range requests are dropped silently.

## Structure
- Package sr_sched_pkg holds:
  - OP_RESET = 1'b0 and OP_SET = 1'b1;
  - default NREQ/NFLAG/IDXW constants;
  - a function returning the next rotated pointer.
- Sub-module rr_arbiter (parameter N): inputs req and ptr; outputs one-hot gnt and the encoded winner. It is purely combinational. The pointer register stays in sr_bank_sched.

## Test plan
- Reset, then req=4'b0001, req_set=1, idx0=5 → gnt=0001 the same cycle; next cycle s=8'h20, r=0; after that q=8'h20.
- All four requesters continuously requesting from ptr=0 → grant order 0,1,2,3,0; each gnt pulse is one cycle; ptr wraps 3→0.
- Req0 sets idx 2 and req1 resets idx 2 in the same cycle → s[2] pulses, then r[2] pulses on the following cycle; final q[2]=0; s&r==0 throughout.
- idx=7 with NFLAG=6 → granted; s=r=0 next cycle; q unchanged; err=1 when SRSCHED_ERR_EN is defined, and stays 1 until reset.
- Reset driven low in the cycle an s pulse is high → s, r and q go to 0 immediately (without waiting for a clock edge); ptr=0 after reset is released.
- Idle bus (req=0) for 5 cycles → gnt=0, s=r=0, busy=0, q held.
